// File: rtl/a0_uart_tx.sv
// rtl/a0_uart_tx.sv - streams every change of the core's a0 tap out of a UART 8N1 line through a word FIFO
// A0_TX_HEX_EN selects 8 hex digits plus newline per word; otherwise 4 raw bytes, least-significant first.
module a0_uart_tx #(
   parameter int DATA_WIDTH   = 32,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] a0,
   output logic                  tx,
   output logic                  busy,
   output logic                  fifo_full,
   output logic [7:0]            drop_cnt
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C     = (AW+1)'(FIFO_DEPTH);
   localparam logic [15:0] BAUD_RELOAD = 16'(CLKS_PER_BIT - 1);
`ifdef A0_TX_HEX_EN
   localparam logic [3:0]  LAST_BYTE   = 4'd8;
`else
   localparam logic [3:0]  LAST_BYTE   = 4'd3;
`endif

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_STOP  = 2'd3;

   logic [DATA_WIDTH-1:0] last_a0;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [AW:0]           count;
   logic [AW:0]           count_next;
   logic [1:0]            state;
   logic [15:0]           baud_cnt;
   logic [2:0]            bit_idx;
   logic [3:0]            byte_idx;
   logic [DATA_WIDTH-1:0] word_q;
   logic [7:0]            byte_sr;
   logic                  push_req;
   logic                  pop;
   logic                  push_ok;

   function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [3:0] idx);
      logic [7:0] res;
`ifdef A0_TX_HEX_EN
      logic [3:0] nib;
      case (idx)
         4'd0:    nib = w[31:28];
         4'd1:    nib = w[27:24];
         4'd2:    nib = w[23:20];
         4'd3:    nib = w[19:16];
         4'd4:    nib = w[15:12];
         4'd5:    nib = w[11:8];
         4'd6:    nib = w[7:4];
         4'd7:    nib = w[3:0];
         default: nib = 4'h0;
      endcase
      if (idx == 4'd8)        res = 8'h0A;
      else if (nib < 4'd10)   res = 8'h30 + {4'h0, nib};
      else                    res = 8'h37 + {4'h0, nib};
`else
      case (idx)
         4'd0:    res = w[7:0];
         4'd1:    res = w[15:8];
         4'd2:    res = w[23:16];
         default: res = w[31:24];
      endcase
`endif
      return res;
   endfunction

   // A push into a full FIFO still succeeds when the transmitter frees a slot on the same edge.
   assign push_req = (a0 != last_a0);
   assign pop      = (state == S_IDLE) && (count != '0);
   assign push_ok  = push_req && ((count != DEPTH_C) || pop);

   always_comb begin
      count_next = count;
      if (push_ok && !pop)      count_next = count + 1'b1;
      else if (pop && !push_ok) count_next = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_a0   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         fifo_full <= 1'b0;
         drop_cnt  <= 8'd0;
      end else begin
         if (push_req) last_a0 <= a0;
         if (push_ok)  wr_ptr  <= wr_ptr + 1'b1;
         if (pop)      rd_ptr  <= rd_ptr + 1'b1;
         count     <= count_next;
         fifo_full <= (count_next == DEPTH_C);
         if (push_req && !push_ok && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= a0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         baud_cnt <= 16'd0;
         bit_idx  <= 3'd0;
         byte_idx <= 4'd0;
         word_q   <= '0;
         byte_sr  <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pop) begin
                  word_q   <= mem[rd_ptr];
                  byte_idx <= 4'd0;
                  byte_sr  <= byte_sel(mem[rd_ptr], 4'd0);
                  baud_cnt <= BAUD_RELOAD;
                  tx       <= 1'b0;
                  busy     <= 1'b1;
                  state    <= S_START;
               end
            end
            S_START: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= BAUD_RELOAD;
                  bit_idx  <= 3'd0;
                  tx       <= byte_sr[0];
                  byte_sr  <= byte_sr >> 1;
                  state    <= S_DATA;
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            S_DATA: begin
               if (baud_cnt == 16'd0) begin
                  baud_cnt <= BAUD_RELOAD;
                  if (bit_idx == 3'd7) begin
                     tx    <= 1'b1;
                     state <= S_STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= byte_sr[0];
                     byte_sr <= byte_sr >> 1;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            S_STOP: begin
               if (baud_cnt == 16'd0) begin
                  if (byte_idx == LAST_BYTE) begin
                     busy  <= 1'b0;
                     state <= S_IDLE;
                  end else begin
                     byte_idx <= byte_idx + 4'd1;
                     byte_sr  <= byte_sel(word_q, byte_idx + 4'd1);
                     baud_cnt <= BAUD_RELOAD;
                     tx       <= 1'b0;
                     state    <= S_START;
                  end
               end else begin
                  baud_cnt <= baud_cnt - 16'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
